program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the instruction-memory fetch path.
- Receives a byte stream from a UART receiver over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the CPU core in reset until the whole program has been written, then releases it.

Parameters:
- ADDR_WIDTH, 12, byte-address width of instruction memory. Capacity = 2^(ADDR_WIDTH-2) words.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset. Clock and reset are fixed: one clock, asynchronous active-low reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte. A transfer occurs when in_valid && in_ready on a rising edge.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
- imem_wren  output  1  instruction memory write strobe, one cycle per word.
- imem_address  output  ADDR_WIDTH  byte address, always a multiple of 4.
- imem_write_data  output  32  assembled word.
- cpu_reset_n  output  1  active-low reset to the CPU core. Low while loading.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.
- words_written  output  ADDR_WIDTH-1  count of words written in the current load.

Behaviour:
- Reset state:
  - state=LEN, in_ready=1, imem_wren=0, imem_address=0, imem_write_data=0.
  - cpu_reset_n=0, done=0, error=0, words_written=0, byte index=0, length register=0.
- All outputs are registered. cpu_reset_n=1 exactly when state==DONE.
- Frame format: 4-byte little-endian word count N, followed by N words of 4 bytes each, LSB first.
- LEN state:
  - in_ready=1. Accepted bytes fill length[8*k+7:8*k] for k=0..3.
  - After the 4th byte:
    - N==0 -> DONE.
    - N > capacity -> ERROR.
    - Otherwise -> DATA, with word address=0.
- DATA state:
  - in_ready=1. Accepted bytes fill the word register, byte 0 into [7:0].
  - On the 4th byte -> WRITE.
- WRITE state (exactly 1 cycle):
  - in_ready=0, imem_wren=1.
  - imem_address = word_index*4; imem_write_data = assembled word.
  - Next edge: word_index+1, words_written+1, imem_address advances by 4, imem_wren returns to 0.
  - Next state: DONE if words_written+1==N, else DATA.
- Latency: imem_wren is asserted in the cycle immediately after the edge that accepted the 4th byte of a word.
- Sustained throughput: one byte per cycle, with one bubble (in_ready=0) per word.
- DONE state: in_ready=0, done=1, cpu_reset_n=1. Further in_valid is ignored (not consumed).
- ERROR state: in_ready=0, error=1, cpu_reset_n=0. No memory writes occur.
- start pulse:
  - Honoured only in DONE or ERROR. Ignored in LEN, DATA and WRITE.
  - Next edge: state=LEN, cpu_reset_n=0, done=0, error=0, words_written=0, byte index=0, imem_address=0.
- Address wrap: cannot occur, because N ≤ capacity is checked before any write.
- Asynchronous reset mid-load:
  - Immediately forces the reset values; the partially assembled word is discarded.
  - Memory contents already written are not cleared.
- Simultaneous in_valid and the transition into WRITE: the byte is not accepted, since in_ready is already 0 in WRITE.

Test Plan:
- Basic load: stream 02 00 00 00, 13 05 50 00, 93 05 a0 00 with in_valid held high.
  - Writes 0x00500513 @0x000, then 0x00A00593 @0x004.
  - done=1, cpu_reset_n=1, words_written=2.
  - Exactly 2 imem_wren pulses.
- Empty program: stream 00 00 00 00 -> DONE after the 4th byte, zero imem_wren pulses, cpu_reset_n rises.
- Oversize: ADDR_WIDTH=12, stream 01 04 00 00 (N=1025 > 1024) -> error=1, cpu_reset_n=0, in_ready=0, no writes.
- Backpressure and gaps:
  - Random in_valid gaps of 0–5 cycles produce the same written data as the basic load.
  - in_ready=0 during every WRITE cycle.
  - A byte presented during WRITE is held and consumed on the following cycle.
- Restart: after DONE, pulse start, then send a 1-word program DEADBEEF (EF BE AD DE).
  - cpu_reset_n drops the cycle after start.
  - Writes 0xDEADBEEF @0x000; words_written=1; done=1.
- Reset mid-word: assert reset_n=0 after 2 data bytes.
  - All outputs return to their reset values immediately.
  - After release, a fresh 1-word frame loads correctly at address 0.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if
//   Groups the loader's two data paths into one bundle:
//     - byte stream from the UART receiver (valid/ready handshake)
//     - instruction-memory write port
//   Signals:
//     in_data          8-bit received byte
//     in_valid         in_data is valid
//     in_ready         loader accepts a byte this cycle
//     imem_wren        instruction memory write strobe, one cycle per word
//     imem_address     byte address of the word being written (multiple of 4)
//     imem_write_data  assembled little-endian 32-bit word
//   Modports:
//     slave  - the loader (consumes bytes, drives the memory port)
//     master - the environment (produces bytes, observes the memory port)
interface program_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_wren;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_write_data;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_wren,
    output imem_address,
    output imem_write_data
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_wren,
    input  imem_address,
    input  imem_write_data
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction-memory fetch path. Consumes a framed byte
//   stream (4-byte little-endian word count N, then N little-endian words),
//   writes the words to instruction memory at consecutive word addresses
//   starting at 0, and holds the CPU in reset until the program is loaded.
//   Ports:
//     clk            system clock
//     reset_n        asynchronous active-low reset
//     start          single-cycle pulse, restarts loading from DONE or ERROR
//     bus            program_loader_if.slave: byte stream in, memory port out
//     cpu_reset_n    active-low CPU reset, high only once the load is done
//     done           load finished successfully
//     error          word count exceeded memory capacity
//     words_written  number of words written in the current load
module program_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  program_loader_if.slave       bus,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] words_written
);

  localparam int WW = ADDR_WIDTH - 1;
  // Capacity in words; one bit wider than the length field so the compare
  // never overflows.
  localparam logic [32:0] CAPACITY = 33'd1 << (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                r_state;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_len;
  logic [23:0]           r_word;
  logic                  r_in_ready;
  logic                  r_imem_wren;
  logic [ADDR_WIDTH-1:0] r_imem_address;
  logic [31:0]           r_imem_write_data;
  logic                  r_cpu_reset_n;
  logic                  r_done;
  logic                  r_error;
  logic [WW-1:0]         r_words_written;

  logic                  w_accept;
  logic [3:0]            w_lane_sel;
  logic [31:0]           w_len_full;
  logic                  w_oversize;
  logic [WW-1:0]         w_words_inc;
  logic                  w_last;

  // in_ready is registered and is only ever high in LEN/DATA, so a transfer
  // can never be taken in WRITE, DONE or ERROR.
  assign w_accept = bus.in_valid && r_in_ready;

  // One-hot byte-lane decode of the current byte position.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_sel[gi] = (r_byte_idx == 2'(gi));
    end
  endgenerate

  // Length as it will be once the 4th byte lands.
  assign w_len_full  = {bus.in_data, r_len[23:0]};
  assign w_oversize  = ({1'b0, w_len_full} > CAPACITY);
  assign w_words_inc = r_words_written + WW'(1);
  assign w_last      = (32'(w_words_inc) == r_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= ST_LEN;
      r_byte_idx        <= 2'd0;
      r_len             <= 32'd0;
      r_word            <= 24'd0;
      r_in_ready        <= 1'b1;
      r_imem_wren       <= 1'b0;
      r_imem_address    <= '0;
      r_imem_write_data <= 32'd0;
      r_cpu_reset_n     <= 1'b0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
      r_words_written   <= '0;
    end else begin
      case (r_state)
        ST_LEN: begin
          if (w_accept) begin
            for (int k = 0; k < 4; k++) begin
              if (w_lane_sel[k]) r_len[8*k +: 8] <= bus.in_data;
            end
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_lane_sel[3]) begin
              if (w_len_full == 32'd0) begin
                r_state       <= ST_DONE;
                r_in_ready    <= 1'b0;
                r_done        <= 1'b1;
                r_cpu_reset_n <= 1'b1;
              end else if (w_oversize) begin
                r_state    <= ST_ERROR;
                r_in_ready <= 1'b0;
                r_error    <= 1'b1;
              end else begin
                r_state        <= ST_DATA;
                r_imem_address <= '0;
              end
            end
          end
        end

        ST_DATA: begin
          if (w_accept) begin
            for (int k = 0; k < 3; k++) begin
              if (w_lane_sel[k]) r_word[8*k +: 8] <= bus.in_data;
            end
            r_byte_idx <= r_byte_idx + 2'd1;
            // The 4th byte goes straight into the output word so the write
            // strobe can fire on the very next cycle.
            if (w_lane_sel[3]) begin
              r_state           <= ST_WRITE;
              r_imem_write_data <= {bus.in_data, r_word};
              r_imem_wren       <= 1'b1;
              r_in_ready        <= 1'b0;
            end
          end
        end

        ST_WRITE: begin
          r_imem_wren     <= 1'b0;
          r_imem_address  <= r_imem_address + ADDR_WIDTH'(4);
          r_words_written <= w_words_inc;
          if (w_last) begin
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_cpu_reset_n <= 1'b1;
          end else begin
            r_state    <= ST_DATA;
            r_in_ready <= 1'b1;
          end
        end

        ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state         <= ST_LEN;
            r_byte_idx      <= 2'd0;
            r_len           <= 32'd0;
            r_in_ready      <= 1'b1;
            r_imem_address  <= '0;
            r_cpu_reset_n   <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_words_written <= '0;
          end
        end

        default: begin
          r_state <= ST_LEN;
        end
      endcase
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.imem_wren       = r_imem_wren;
  assign bus.imem_address    = r_imem_address;
  assign bus.imem_write_data = r_imem_write_data;
  assign cpu_reset_n         = r_cpu_reset_n;
  assign done                = r_done;
  assign error               = r_error;
  assign words_written       = r_words_written;

endmodule
